serial_adder_array: RTL and testbench

Parametrised, multi-channel successor to the single-lane bit-serial adder. `CHANNELS` independent lanes each add or subtract two LSB-first two's-complement serial operands of `WIDTH` bits. The lanes share one word-framing controller: start strobe, bit counter, stall support, last-bit marker, and per-lane signed overflow. The block sits between the bit-serial operand streams and the bit-serial accumulators/neurons of the etchnet datapath.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_lane.sv | 52 +++++
 rtl/serial_adder_array.sv | 74 +++++++
 tb/tb_serial_adder_array.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type, mode constants and counter sizing for serial_adder_array.
package serial_adder_pkg;
   typedef enum logic {
      SA_IDLE = 1'b0,
      SA_RUN  = 1'b1
   } sa_state_e;
   localparam logic SA_ADD = 1'b0;
   localparam logic SA_SUB = 1'b1;
   function automatic int cnt_w(input int width);
      return ($clog2(width) < 1) ? 1 : $clog2(width);
   endfunction
endpackage

// File: rtl/serial_adder_lane.sv
// serial_adder_lane: one bit-serial add/sub lane; overflow register only with SERIAL_ADDER_OVF_EN.
module serial_adder_lane
   import serial_adder_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic accept,
   input  logic first,
   input  logic last,
   input  logic sub,
   input  logic in1,
   input  logic in2,
   output logic sum,
   output logic ovf
);
   logic r_mode;
   logic r_carry;
   logic r_sum;
   logic w_mode;
   logic w_cin;
   logic w_b;
   logic w_s;
   logic w_cout;
   // On the start beat the fresh sub bit acts as both mode and carry-in (two's-complement negate).
   assign w_mode = first ? sub : r_mode;
   assign w_cin  = first ? sub : r_carry;
   assign w_b    = in2 ^ w_mode;
   assign w_s    = in1 ^ w_b ^ w_cin;
   assign w_cout = (in1 & w_b) | (in1 & w_cin) | (w_b & w_cin);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode  <= SA_ADD;
         r_carry <= 1'b0;
         r_sum   <= 1'b0;
      end else if (accept) begin
         r_sum   <= w_s;
         r_carry <= last ? 1'b0 : w_cout;
         if (first) r_mode <= sub;
      end
   end
   assign sum = r_sum;
`ifdef SERIAL_ADDER_OVF_EN
   logic r_ovf;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ovf <= 1'b0;
      else if (accept && last) r_ovf <= w_cin ^ w_cout;
   end
   assign ovf = r_ovf;
`else
   assign ovf = 1'b0;
`endif
endmodule

// File: rtl/serial_adder_array.sv
// serial_adder_array: CHANNELS bit-serial add/sub lanes sharing one word-framing controller.
// Define SERIAL_ADDER_OVF_EN to build per-lane signed overflow; otherwise ovf is tied to 0.
module serial_adder_array
   import serial_adder_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                in_valid,
   input  logic [CHANNELS-1:0] sub,
   input  logic [CHANNELS-1:0] in1,
   input  logic [CHANNELS-1:0] in2,
   output logic [CHANNELS-1:0] sum,
   output logic                sum_valid,
   output logic                sum_last,
   output logic                busy,
   output logic [CHANNELS-1:0] ovf
);
   localparam int CW = cnt_w(WIDTH);
   sa_state_e r_state;
   sa_state_e w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic r_sum_valid;
   logic r_sum_last;
   logic w_run;
   logic w_first;
   logic w_accept;
   logic w_last;
   assign w_run    = (r_state == SA_RUN);
   assign w_first  = in_valid & start;
   assign w_accept = in_valid & (start | w_run);
   // A start beat always begins a new word, so it can never be the MSB of the old one.
   assign w_last   = in_valid & ~start & w_run & (r_cnt == CW'(WIDTH - 1));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= SA_IDLE;
      else r_state <= w_state_nxt;
   end
   always_comb begin
      w_state_nxt = r_state;
      w_state_nxt = w_first ? SA_RUN : (w_last ? SA_IDLE : r_state);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_sum_valid <= 1'b0;
         r_sum_last  <= 1'b0;
      end else begin
         r_sum_valid <= w_accept;
         r_sum_last  <= w_last;
         if (w_first) r_cnt <= CW'(1);
         else if (w_accept) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
   end
   assign busy      = w_run;
   assign sum_valid = r_sum_valid;
   assign sum_last  = r_sum_last;
   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      serial_adder_lane u_lane (
         .clk    (clk),
         .rst_n  (rst_n),
         .accept (w_accept),
         .first  (w_first),
         .last   (w_last),
         .sub    (sub[g]),
         .in1    (in1[g]),
         .in2    (in2[g]),
         .sum    (sum[g]),
         .ovf    (ovf[g])
      );
   end
endmodule

// File: tb/tb_serial_adder_array.sv
// tb_serial_adder_array: scoreboard bench for serial_adder_array; expected ovf follows SERIAL_ADDER_OVF_EN.
module tb_serial_adder_array;
   localparam int CH = 4;
   localparam int W  = 8;
`ifdef SERIAL_ADDER_OVF_EN
   localparam logic [CH-1:0] OVF_MASK = '1;
`else
   localparam logic [CH-1:0] OVF_MASK = '0;
`endif
   typedef logic [CH-1:0][W-1:0] word_t;
   typedef struct {
      logic [CH-1:0] bits;
      logic          last;
      logic [CH-1:0] ovf;
   } exp_t;
   typedef struct {
      word_t         w;
      logic [CH-1:0] ovf;
   } res_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic in_valid = 1'b0;
   logic [CH-1:0] sub = '0;
   logic [CH-1:0] in1 = '0;
   logic [CH-1:0] in2 = '0;
   logic [CH-1:0] sum;
   logic sum_valid;
   logic sum_last;
   logic busy;
   logic [CH-1:0] ovf;
   int total = 0;
   int bad = 0;
   exp_t sb[$];
   res_t done_q[$];
   word_t cap = '0;
   exp_t e;
   res_t res;

   serial_adder_array #(.CHANNELS(CH), .WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .sub(sub),
      .in1(in1), .in2(in2), .sum(sum), .sum_valid(sum_valid), .sum_last(sum_last),
      .busy(busy), .ovf(ovf)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && sum_valid) begin
         for (int i = 0; i < CH; i++) cap[i] = {sum[i], cap[i][W-1:1]};
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL stream: unexpected sum_valid sum=%b sum_last=%b", sum, sum_last);
         end else begin
            e = sb.pop_front();
            if (sum !== e.bits || sum_last !== e.last || (e.last && ovf !== e.ovf)) begin
               bad++;
               $display("FAIL stream: got sum=%b last=%b ovf=%b, want sum=%b last=%b ovf=%b",
                        sum, sum_last, ovf, e.bits, e.last, e.ovf);
            end
         end
         if (sum_last) done_q.push_back('{cap, ovf});
      end
   end

   task automatic drive_word(input word_t a, input word_t b, input logic [CH-1:0] sb_m,
                             input int nbits, input int stall_at, input int stall_len);
      word_t r;
      logic [CH-1:0] ov;
      exp_t x;
      for (int i = 0; i < CH; i++) begin
         r[i] = sb_m[i] ? a[i] - b[i] : a[i] + b[i];
         ov[i] = sb_m[i] ? (a[i][W-1] != b[i][W-1] && r[i][W-1] != a[i][W-1])
                         : (a[i][W-1] == b[i][W-1] && r[i][W-1] != a[i][W-1]);
      end
      for (int k = 0; k < nbits; k++) begin
         @(negedge clk);
         start = (k == 0);
         in_valid = 1'b1;
         sub = (k == 0) ? sb_m : ~sb_m;
         for (int i = 0; i < CH; i++) begin
            in1[i] = a[i][k];
            in2[i] = b[i][k];
            x.bits[i] = r[i][k];
         end
         x.last = (k == W - 1);
         x.ovf = ov & OVF_MASK;
         sb.push_back(x);
         if (k == stall_at) begin
            for (int s = 0; s < stall_len; s++) begin
               @(negedge clk);
               if (s > 0) begin
                  total++;
                  if (sum_valid !== 1'b0 || busy !== 1'b1) begin
                     bad++;
                     $display("FAIL stall_gap: got sum_valid=%b busy=%b, want 0 1", sum_valid, busy);
                  end
               end
               start = 1'b0;
               in_valid = 1'b0;
               in1 = CH'($urandom);
               in2 = CH'($urandom);
            end
         end
      end
   endtask

   task automatic go_idle();
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      #1;
      total++;
      if ({sum, sum_valid, sum_last, busy, ovf} !== '0) begin
         bad++;
         $display("FAIL reset: got sum=%b sv=%b sl=%b busy=%b ovf=%b, want all 0",
                  sum, sum_valid, sum_last, busy, ovf);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      drive_word({8'd0, 8'hFF, 8'd100, 8'd3}, {8'd0, 8'd1, 8'd27, 8'd5}, 4'b0000, W, -1, 0);
      go_idle();
      total++;
      if (done_q.size() == 0) begin
         bad++;
         $display("FAIL add: no word completed, want one");
      end else begin
         res = done_q.pop_front();
         if (res.w !== {8'd0, 8'd0, 8'd127, 8'd8} || res.ovf !== 4'b0000) begin
            bad++;
            $display("FAIL add: got %h ovf=%b, want 00007f08 ovf=0000", res.w, res.ovf);
         end
      end
   endtask

   task automatic test_sub();
      drive_word({8'd50, 8'h80, 8'd7, 8'd100}, {8'd60, 8'd1, 8'd9, 8'd28}, 4'b0101, W, -1, 0);
      go_idle();
      total++;
      if (done_q.size() == 0) begin
         bad++;
         $display("FAIL sub: no word completed, want one");
      end else begin
         res = done_q.pop_front();
         if (res.w !== {8'd110, 8'd127, 8'd16, 8'd72} || res.ovf !== (4'b0100 & OVF_MASK)) begin
            bad++;
            $display("FAIL sub: got %h ovf=%b, want 6e7f1048 ovf=%b", res.w, res.ovf, 4'b0100 & OVF_MASK);
         end
      end
   endtask

   task automatic test_back_to_back();
      drive_word({8'd64, 8'd10, 8'd127, 8'h9C}, {8'd64, 8'd20, 8'd1, 8'h9C}, 4'b0000, W, -1, 0);
      drive_word({8'd1, 8'd1, 8'd1, 8'd1}, {8'd1, 8'd1, 8'd1, 8'd1}, 4'b0000, W, -1, 0);
      go_idle();
      total++;
      if (done_q.size() != 2) begin
         bad++;
         $display("FAIL b2b_count: got %0d words, want 2", done_q.size());
         done_q.delete();
      end else begin
         res = done_q.pop_front();
         if (res.w !== {8'h80, 8'd30, 8'h80, 8'h38} || res.ovf !== (4'b1011 & OVF_MASK)) begin
            bad++;
            $display("FAIL b2b_ovf: got %h ovf=%b, want 801e8038 ovf=%b", res.w, res.ovf, 4'b1011 & OVF_MASK);
         end
         total++;
         res = done_q.pop_front();
         if (res.w !== {8'd2, 8'd2, 8'd2, 8'd2} || res.ovf !== 4'b0000) begin
            bad++;
            $display("FAIL b2b_clear: got %h ovf=%b, want 02020202 ovf=0000", res.w, res.ovf);
         end
      end
   endtask

   task automatic test_stall();
      drive_word({8'h7F, 8'd1, 8'hFB, 8'd45}, {8'hFF, 8'd2, 8'd3, 8'd19}, 4'b1010, W, 3, 3);
      go_idle();
      total++;
      if (done_q.size() == 0) begin
         bad++;
         $display("FAIL stall: no word completed, want one");
      end else begin
         res = done_q.pop_front();
         if (res.w !== {8'h80, 8'd3, 8'hF8, 8'd64} || res.ovf !== (4'b1000 & OVF_MASK)) begin
            bad++;
            $display("FAIL stall: got %h ovf=%b, want 8003f840 ovf=%b", res.w, res.ovf, 4'b1000 & OVF_MASK);
         end
      end
   endtask

   task automatic test_restart();
      drive_word({8'd77, 8'd77, 8'd77, 8'd77}, {8'd33, 8'd33, 8'd33, 8'd33}, 4'b1111, 5, -1, 0);
      drive_word({8'd10, 8'd10, 8'd10, 8'd10}, {8'd20, 8'd20, 8'd20, 8'd20}, 4'b1000, W, -1, 0);
      go_idle();
      total++;
      if (done_q.size() != 1) begin
         bad++;
         $display("FAIL restart_count: got %0d words, want 1", done_q.size());
         done_q.delete();
      end else begin
         res = done_q.pop_front();
         if (res.w !== {8'hF6, 8'd30, 8'd30, 8'd30} || res.ovf !== 4'b0000) begin
            bad++;
            $display("FAIL restart: got %h ovf=%b, want f61e1e1e ovf=0000", res.w, res.ovf);
         end
      end
   endtask

   task automatic test_reset_mid_word();
      drive_word({8'd90, 8'd90, 8'd90, 8'd90}, {8'd5, 8'd5, 8'd5, 8'd5}, 4'b0000, 4, -1, 0);
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
      in1 = '1;
      in2 = '0;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({sum, sum_valid, sum_last, busy, ovf} !== '0) begin
         bad++;
         $display("FAIL reset_mid: got sum=%b sv=%b sl=%b busy=%b ovf=%b, want all 0",
                  sum, sum_valid, sum_last, busy, ovf);
      end
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      total++;
      if (sb.size() != 0 || done_q.size() != 0) begin
         bad++;
         $display("FAIL reset_mid_queue: got pending=%0d words=%0d, want 0 0", sb.size(), done_q.size());
      end
      sb.delete();
      done_q.delete();
   endtask

   task automatic test_idle_inputs();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k > 0) begin
            total++;
            if (sum_valid !== 1'b0 || busy !== 1'b0) begin
               bad++;
               $display("FAIL idle_in: got sum_valid=%b busy=%b, want 0 0", sum_valid, busy);
            end
         end
         start = (k >= 4);
         in_valid = (k < 4);
         in1 = CH'($urandom);
         in2 = CH'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      total++;
      if (sum_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_start: got sum_valid=%b busy=%b, want 0 0", sum_valid, busy);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_back_to_back();
      test_stall();
      test_restart();
      test_reset_mid_word();
      test_idle_inputs();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending beats, want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
